sd_read_arbiter: RTL and testbench

//  Shares the single sd_card read port between two requesters and sequences each
//  512-byte block read. Round-robin arbitration, one rd_req pulse per grant,

---
 rtl/sd_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_sd_read_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_read_arbiter.sv
`timescale 1ns/1ps
// sd_read_arbiter: round-robin owner of the sd_card read port for two requesters.
// Issues one rd_req per grant, steers the 512 streamed bytes into the owner's half
// of a 1 KB SRAM, then pulses done (with err if the watchdog fired).
module sd_read_arbiter #(
    parameter int unsigned BLK_BYTES = 512,
    parameter int unsigned TIMEOUT   = 1 << 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_finished,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic        sd_rd_req,
    output logic [31:0] sd_block_addr,
    input  logic        sd_valid,
    input  logic [7:0]  sd_dout,
    output logic        sram_we,
    output logic [9:0]  sram_addr,
    output logic [7:0]  sram_din,
    output logic        busy
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BLK_BYTES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_XFER  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [31:0]        addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               err_d;
    logic               grant_id;
    logic               own_d;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not go last.
    assign grant_id = (req0 && req1) ? ~last_owner_q : req1;

    // Next-state and next-register values.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = sd_block_addr;
        cnt_d        = cnt_q;
        wdog_d       = wdog_q;
        err_d        = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (init_finished) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!init_finished) begin
                    state_d = S_INIT;
                end else if (req0 || req1) begin
                    owner_d = grant_id;
                    addr_d  = grant_id ? addr1 : addr0;
                    cnt_d   = '0;
                    wdog_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_XFER;
            end
            S_XFER: begin
                if (sd_valid) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    wdog_d = '0;
                    if (cnt_q == LAST_BYTE) state_d = S_DONE;
                end else if (wdog_q == WDOG_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Port is owned from ISSUE through DONE inclusive.
    assign own_d = (state_d == S_ISSUE) || (state_d == S_XFER) || (state_d == S_DONE);

    // State, context and registered outputs; outputs are decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_INIT;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            sd_block_addr <= '0;
            cnt_q         <= '0;
            wdog_q        <= '0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err           <= 1'b0;
            sd_rd_req     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            sd_block_addr <= addr_d;
            cnt_q         <= cnt_d;
            wdog_q        <= wdog_d;
            gnt0          <= own_d && !owner_d;
            gnt1          <= own_d && owner_d;
            done0         <= (state_d == S_DONE) && !owner_d;
            done1         <= (state_d == S_DONE) && owner_d;
            err           <= err_d;
            sd_rd_req     <= (state_d == S_ISSUE);
            busy          <= (state_d != S_IDLE);
        end
    end

    // SRAM write port: bytes pass straight through while streaming.
    assign sram_we   = sd_valid && (state_q == S_XFER);
    assign sram_addr = {owner_q, cnt_q[8:0]};
    assign sram_din  = sd_dout;

endmodule

// File: tb/tb_sd_read_arbiter.sv
`timescale 1ns/1ps
// Directed bench for sd_read_arbiter: init gating, single block, reset abort,
// round-robin, watchdog timeout and stray strobes.
module tb_sd_read_arbiter;

    localparam int unsigned BLK     = 512;
    localparam int unsigned TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_finished = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] addr1 = '0;
    logic        gnt0, gnt1, done0, done1, err, sd_rd_req;
    logic [31:0] sd_block_addr;
    logic        sd_valid = 1'b0;
    logic [7:0]  sd_dout = '0;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_din;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    sd_read_arbiter #(.BLK_BYTES(BLK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .init_finished(init_finished),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .sd_rd_req(sd_rd_req), .sd_block_addr(sd_block_addr),
        .sd_valid(sd_valid), .sd_dout(sd_dout),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stream n beats starting at a negedge in XFER; counts beats whose write is wrong.
    task automatic stream(input int n, input logic own, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            sd_valid = 1'b1;
            sd_dout  = 8'(i * 7 + 3);
            #1;
            if (sram_we !== 1'b1 || sram_addr !== {own, 9'(i)} || sram_din !== sd_dout ||
                done0 !== 1'b0 || done1 !== 1'b0) bad++;
            @(negedge clk);
        end
        sd_valid = 1'b0;
    endtask

    // Wait (bounded) for sd_rd_req; cyc = negedges taken, -1 if it never came.
    task automatic wait_issue(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sd_rd_req === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, done0, done1, err, sd_rd_req, sram_we, busy} !== 8'h00)
            $display("FAIL reset_ctrl: got %b want 00000000", {gnt0, gnt1, done0, done1, err, sd_rd_req, sram_we, busy});
        else n_pass++;
        n_checks++;
        if (sd_block_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", sd_block_addr);
        else n_pass++;
        n_checks++;
        if (sram_addr !== 10'h000) $display("FAIL reset_sram_addr: got %h want 000", sram_addr);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_init_wait();
        int seen;
        int bad;
        seen  = 0;
        req0  = 1'b1;
        addr0 = 32'h0000_1234;
        repeat (100) begin
            @(negedge clk);
            if (sd_rd_req === 1'b1 || gnt0 === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL init_block: got %0d issue cycles want 0", seen);
        else n_pass++;
        init_finished = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sd_rd_req !== 1'b0) $display("FAIL init_idle: got sd_rd_req=%b want 0", sd_rd_req);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({sd_rd_req, gnt0, gnt1} !== 3'b110) $display("FAIL init_issue: got %b want 110", {sd_rd_req, gnt0, gnt1});
        else n_pass++;
        n_checks++;
        if (sd_block_addr !== 32'h0000_1234) $display("FAIL init_addr: got %h want 00001234", sd_block_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sd_rd_req !== 1'b0) $display("FAIL issue_one_cycle: got %b want 0", sd_rd_req);
        else n_pass++;
        stream(BLK, 1'b0, bad);
        n_checks++;
        if (bad !== 0 || done0 !== 1'b1) $display("FAIL init_block_xfer: got bad=%0d done0=%b want 0/1", bad, done0);
        else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_block();
        int cyc;
        int bad;
        req0  = 1'b1;
        addr0 = 32'h0000_2000;
        wait_issue(cyc);
        n_checks++;
        if (cyc !== 1) $display("FAIL single_latency: got %0d want 1", cyc);
        else n_pass++;
        n_checks++;
        if (sd_block_addr !== 32'h0000_2000 || gnt0 !== 1'b1 || gnt1 !== 1'b0)
            $display("FAIL single_grant: got addr=%h gnt=%b%b want 00002000 10", sd_block_addr, gnt0, gnt1);
        else n_pass++;
        @(negedge clk);
        stream(BLK, 1'b0, bad);
        n_checks++;
        if (bad !== 0) $display("FAIL single_writes: got %0d bad beats want 0", bad);
        else n_pass++;
        n_checks++;
        if ({done0, done1, err, gnt0} !== 4'b1001) $display("FAIL single_done: got %b want 1001", {done0, done1, err, gnt0});
        else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done0, gnt0, busy} !== 3'b000) $display("FAIL single_release: got %b want 000", {done0, gnt0, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        int seen;
        req0  = 1'b1;
        addr0 = 32'h0000_7000;
        wait_issue(cyc);
        @(negedge clk);
        stream(300, 1'b0, bad);
        n_checks++;
        if (bad !== 0) $display("FAIL rstmid_writes: got %0d bad beats want 0", bad);
        else n_pass++;
        sd_valid = 1'b1;
        rst      = 1'b1;
        #1;
        n_checks++;
        if ({sd_rd_req, gnt0, gnt1, sram_we, busy} !== 5'b00000)
            $display("FAIL rstmid_outputs: got %b want 00000", {sd_rd_req, gnt0, gnt1, sram_we, busy});
        else n_pass++;
        n_checks++;
        if (sd_block_addr !== 32'h0) $display("FAIL rstmid_addr: got %h want 0", sd_block_addr);
        else n_pass++;
        sd_valid      = 1'b0;
        init_finished = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 === 1'b1 || done1 === 1'b1 || err === 1'b1 || sd_rd_req === 1'b1 || gnt0 === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", seen);
        else n_pass++;
        req0          = 1'b0;
        init_finished = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int cyc;
        int bad;
        logic e;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h0000_4000;
        addr1 = 32'h0000_3000;
        for (int g = 0; g < 4; g++) begin
            e = 1'(g % 2);
            wait_issue(cyc);
            n_checks++;
            if (cyc !== ((g == 0) ? 1 : 2)) $display("FAIL rr_latency_%0d: got %0d want %0d", g, cyc, (g == 0) ? 1 : 2);
            else n_pass++;
            n_checks++;
            if ({gnt1, gnt0} !== (e ? 2'b10 : 2'b01) || sd_block_addr !== (e ? 32'h0000_3000 : 32'h0000_4000))
                $display("FAIL rr_grant_%0d: got gnt=%b%b addr=%h want owner %0d", g, gnt1, gnt0, sd_block_addr, e);
            else n_pass++;
            @(negedge clk);
            stream(BLK, e, bad);
            n_checks++;
            if (bad !== 0 || {done1, done0} !== (e ? 2'b10 : 2'b01))
                $display("FAIL rr_block_%0d: got bad=%0d done=%b%b want 0 owner %0d", g, bad, done1, done0, e);
            else n_pass++;
            if (g == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1} !== 2'b00) $display("FAIL rr_release: got %b want 00", {gnt0, gnt1});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc;
        int bad;
        int k;
        req0  = 1'b1;
        addr0 = 32'h0000_8000;
        wait_issue(cyc);
        @(negedge clk);
        stream(100, 1'b0, bad);
        k = 0;
        while (done0 !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== TIMEOUT) $display("FAIL timeout_delay: got %0d cycles want %0d", k, TIMEOUT);
        else n_pass++;
        n_checks++;
        if ({done0, err, gnt0} !== 3'b111) $display("FAIL timeout_err: got %b want 111", {done0, err, gnt0});
        else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err, gnt0, done0} !== 3'b000) $display("FAIL timeout_clear: got %b want 000", {err, gnt0, done0});
        else n_pass++;
        req1  = 1'b1;
        addr1 = 32'h0000_5000;
        wait_issue(cyc);
        n_checks++;
        if (cyc !== 1 || gnt1 !== 1'b1 || sd_block_addr !== 32'h0000_5000)
            $display("FAIL after_timeout_grant: got cyc=%0d gnt1=%b addr=%h want 1 1 00005000", cyc, gnt1, sd_block_addr);
        else n_pass++;
        @(negedge clk);
        stream(BLK, 1'b1, bad);
        n_checks++;
        if (bad !== 0 || {done1, err} !== 2'b10) $display("FAIL after_timeout_block: got bad=%0d done1/err=%b want 0 10", bad, {done1, err});
        else n_pass++;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray();
        int cyc;
        int bad;
        int we_seen;
        we_seen  = 0;
        sd_valid = 1'b1;
        repeat (3) begin
            #1;
            if (sram_we !== 1'b0) we_seen++;
            @(negedge clk);
        end
        sd_valid = 1'b0;
        n_checks++;
        if (we_seen !== 0 || sram_addr !== 10'h200) $display("FAIL stray_idle: got we=%0d addr=%h want 0 200", we_seen, sram_addr);
        else n_pass++;
        req0  = 1'b1;
        addr0 = 32'h0000_6000;
        wait_issue(cyc);
        @(negedge clk);
        stream(BLK, 1'b0, bad);
        sd_valid = 1'b1;
        #1;
        n_checks++;
        if ({sram_we, done0} !== 2'b01 || sram_addr !== 10'h000)
            $display("FAIL stray_done: got we/done=%b addr=%h want 01 000", {sram_we, done0}, sram_addr);
        else n_pass++;
        req0 = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({sram_we, busy} !== 2'b00 || sram_addr !== 10'h000)
            $display("FAIL stray_after_done: got we/busy=%b addr=%h want 00 000", {sram_we, busy}, sram_addr);
        else n_pass++;
        sd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_wait();
        test_single_block();
        test_reset_mid();
        test_round_robin();
        test_timeout();
        test_stray();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish before 500000ns");
        $fatal(1, "simulation time limit");
    end

endmodule
